otter_mmio_hub: RTL and testbench

//  Parametrised memory-mapped I/O hub between OTTER_MCU iobus and board devices.

---
 rtl/otter_mmio_hub_pkg.sv | 28 ++
 rtl/otter_mmio_hub_if.sv | 23 ++
 rtl/otter_mmio_hub_btn_debounce.sv | 56 +++++
 rtl/otter_mmio_hub.sv | 146 ++++++++++++++
 tb/tb_otter_mmio_hub.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/otter_mmio_hub_pkg.sv
// Shared definitions for the OTTER MMIO hub: default base addresses,
// address decode selector and the word-offset helper.
package otter_io_pkg;

    localparam logic [31:0] DEF_BASE_IN  = 32'h1100_8000;
    localparam logic [31:0] DEF_BASE_OUT = 32'h1100_C000;

    // Widest button/pending/mask vector the hub supports.
    localparam int unsigned MAX_BTN = 16;
    typedef logic [MAX_BTN-1:0] irq_vec_t;

    // Which register an iobus address selects.
    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_EXT,   // synchronised input port (read only)
        SEL_BTN,   // debounced buttons (read only)
        SEL_PEND,  // pending, read-only alias in the input region
        SEL_OUT,   // output register (read/write)
        SEL_MASK,  // interrupt mask (read/write)
        SEL_CLR    // pending, write-1-to-clear alias in the output region
    } sel_e;

    // Byte address of the given word slot above a region base.
    function automatic logic [31:0] io_offset(input logic [31:0] base, input int unsigned word);
        return base + 32'(word * 4);
    endfunction

endpackage

// File: rtl/otter_mmio_hub_if.sv
// OTTER_MCU iobus: address, write data and strobe from the MCU, read data back.
interface otter_mmio_hub_if;

    logic [31:0] iobus_addr;
    logic [31:0] iobus_out;
    logic        iobus_wr;
    logic [31:0] iobus_in;

    modport master (
        output iobus_addr,
        output iobus_out,
        output iobus_wr,
        input  iobus_in
    );

    modport slave (
        input  iobus_addr,
        input  iobus_out,
        input  iobus_wr,
        output iobus_in
    );

endinterface

// File: rtl/otter_mmio_hub_btn_debounce.sv
// One button: 2-flop synchroniser, stability counter and debounced level.
// rise_o marks the clock edge on which the debounced level goes 0 -> 1.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 500_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_raw_i,
    output logic db_o,
    output logic rise_o
);

    localparam int unsigned     CW      = $clog2(DB_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          db_q;
    logic          db_d;

    // Synchroniser, counter and debounced state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
        end
    end

    // Count consecutive cycles of disagreement; accept the new level once stable.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_MAX) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Taken from the next-state value so pending is set on the same edge db rises.
    assign rise_o = db_d & ~db_q;
    assign db_o   = db_q;

endmodule

// File: rtl/otter_mmio_hub.sv
// Memory-mapped I/O hub between the OTTER_MCU iobus and board devices:
// output registers, synchronised input ports, debounced buttons with
// rising-edge capture and a maskable level interrupt.
module otter_mmio_hub
    import otter_io_pkg::*;
#(
    parameter logic [31:0] BASE_IN   = DEF_BASE_IN,
    parameter logic [31:0] BASE_OUT  = DEF_BASE_OUT,
    parameter int unsigned N_IN      = 4,
    parameter int unsigned IN_W      = 16,
    parameter int unsigned N_OUT     = 4,
    parameter int unsigned OUT_W     = 32,
    parameter int unsigned N_BTN     = 5,
    parameter int unsigned DB_CYCLES = 500_000
) (
    input  logic                   clk,
    input  logic                   RST,
    otter_mmio_hub_if.slave        bus,
    input  logic [N_IN*IN_W-1:0]   ext_in,
    input  logic [N_BTN-1:0]       btn_raw,
    output logic [N_OUT*OUT_W-1:0] out_regs,
    output logic                   intr
);

    logic [N_IN*IN_W-1:0]   ext_s1_q;
    logic [N_IN*IN_W-1:0]   ext_s2_q;
    logic [N_OUT*OUT_W-1:0] out_q;
    logic [N_OUT*OUT_W-1:0] out_d;
    logic [N_BTN-1:0]       mask_q;
    logic [N_BTN-1:0]       mask_d;
    logic [N_BTN-1:0]       pend_q;
    logic [N_BTN-1:0]       pend_d;
    logic [N_BTN-1:0]       clr;
    logic [N_BTN-1:0]       db;
    logic [N_BTN-1:0]       rise;
    logic                   intr_q;
    logic                   intr_d;
    sel_e                   sel;
    logic [3:0]             sel_idx;
    logic [31:0]            rdata;
    irq_vec_t               db_wide;
    irq_vec_t               pend_wide;

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk_i    (clk),
            .rst_i    (RST),
            .btn_raw_i(btn_raw[g]),
            .db_o     (db[g]),
            .rise_o   (rise[g])
        );
    end

    // Address decode shared by the read mux and the write enables.
    always_comb begin
        sel     = SEL_NONE;
        sel_idx = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (bus.iobus_addr == io_offset(BASE_IN, i)) begin
                sel     = SEL_EXT;
                sel_idx = 4'(i);
            end
        end
        if (bus.iobus_addr == io_offset(BASE_IN, N_IN))     sel = SEL_BTN;
        if (bus.iobus_addr == io_offset(BASE_IN, N_IN + 1)) sel = SEL_PEND;
        for (int unsigned i = 0; i < N_OUT; i++) begin
            if (bus.iobus_addr == io_offset(BASE_OUT, i)) begin
                sel     = SEL_OUT;
                sel_idx = 4'(i);
            end
        end
        if (bus.iobus_addr == io_offset(BASE_OUT, N_OUT))     sel = SEL_MASK;
        if (bus.iobus_addr == io_offset(BASE_OUT, N_OUT + 1)) sel = SEL_CLR;
    end

    assign db_wide   = irq_vec_t'(db);
    assign pend_wide = irq_vec_t'(pend_q);

    // Zero-latency, zero-extended read mux; unmapped addresses read as 0.
    always_comb begin
        rdata = '0;
        case (sel)
            SEL_EXT: begin
                for (int unsigned i = 0; i < N_IN; i++) begin
                    if (sel_idx == 4'(i)) rdata = 32'(ext_s2_q[i*IN_W +: IN_W]);
                end
            end
            SEL_OUT: begin
                for (int unsigned i = 0; i < N_OUT; i++) begin
                    if (sel_idx == 4'(i)) rdata = 32'(out_q[i*OUT_W +: OUT_W]);
                end
            end
            SEL_BTN:           rdata = 32'(db_wide);
            SEL_PEND, SEL_CLR: rdata = 32'(pend_wide);
            SEL_MASK:          rdata = 32'(mask_q);
            default:           rdata = '0;
        endcase
    end

    // Next-state for writable registers; a new rising edge wins over W1C.
    always_comb begin
        out_d  = out_q;
        mask_d = mask_q;
        clr    = '0;
        if (bus.iobus_wr) begin
            case (sel)
                SEL_OUT: begin
                    for (int unsigned i = 0; i < N_OUT; i++) begin
                        if (sel_idx == 4'(i)) out_d[i*OUT_W +: OUT_W] = bus.iobus_out[OUT_W-1:0];
                    end
                end
                SEL_MASK: mask_d = bus.iobus_out[N_BTN-1:0];
                SEL_CLR:  clr    = bus.iobus_out[N_BTN-1:0];
                default:  ;
            endcase
        end
        pend_d = (pend_q & ~clr) | rise;
        intr_d = |(pend_q & mask_q);
    end

    // Input synchronisers, register file and interrupt flop.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            ext_s1_q <= '0;
            ext_s2_q <= '0;
            out_q    <= '0;
            mask_q   <= '0;
            pend_q   <= '0;
            intr_q   <= 1'b0;
        end else begin
            ext_s1_q <= ext_in;
            ext_s2_q <= ext_s1_q;
            out_q    <= out_d;
            mask_q   <= mask_d;
            pend_q   <= pend_d;
            intr_q   <= intr_d;
        end
    end

    assign bus.iobus_in = rdata;
    assign out_regs     = out_q;
    assign intr         = intr_q;

endmodule

// File: tb/tb_otter_mmio_hub.sv
// Scoreboard bench for otter_mmio_hub: the driver pushes expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_otter_mmio_hub;

    localparam int unsigned N_IN  = 4;
    localparam int unsigned IN_W  = 16;
    localparam int unsigned N_OUT = 4;
    localparam int unsigned OUT_W = 32;
    localparam int unsigned N_BTN = 5;
    localparam int unsigned DB    = 8;

    localparam logic [31:0] B_IN   = 32'h1100_8000;
    localparam logic [31:0] B_OUT  = 32'h1100_C000;
    localparam logic [31:0] BTN_A  = B_IN + 32'd16;
    localparam logic [31:0] PEND_A = B_IN + 32'd20;
    localparam logic [31:0] MASK_A = B_OUT + 32'd16;
    localparam logic [31:0] CLR_A  = B_OUT + 32'd20;

    localparam int unsigned K_RD   = 0;
    localparam int unsigned K_INTR = 1;
    localparam int unsigned K_OUT  = 2;

    logic                   clk = 1'b0;
    logic                   RST;
    logic [N_IN*IN_W-1:0]   ext_in;
    logic [N_BTN-1:0]       btn_raw;
    logic [N_OUT*OUT_W-1:0] out_regs;
    logic                   intr;

    otter_mmio_hub_if bus ();

    otter_mmio_hub #(
        .BASE_IN  (B_IN),
        .BASE_OUT (B_OUT),
        .N_IN     (N_IN),
        .IN_W     (IN_W),
        .N_OUT    (N_OUT),
        .OUT_W    (OUT_W),
        .N_BTN    (N_BTN),
        .DB_CYCLES(DB)
    ) dut (
        .clk     (clk),
        .RST     (RST),
        .bus     (bus.slave),
        .ext_in  (ext_in),
        .btn_raw (btn_raw),
        .out_regs(out_regs),
        .intr    (intr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        int unsigned kind;
        int unsigned idx;
        logic [31:0] v;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state.
    logic [31:0]      m_out[N_OUT];
    logic [N_BTN-1:0] m_mask;
    logic [N_BTN-1:0] m_pend;
    logic [N_BTN-1:0] m_db;
    logic [IN_W-1:0]  m_d1[N_IN];
    logic [IN_W-1:0]  m_d2[N_IN];

    // Monitor: compare everything queued for this cycle.
    exp_t        e;
    logic [31:0] act;
    always @(negedge clk) begin
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            case (e.kind)
                K_RD:    act = bus.iobus_in;
                K_INTR:  act = {31'd0, intr};
                default: act = out_regs[e.idx*OUT_W +: OUT_W];
            endcase
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s actual=%h required=%h t=%0t", e.nm, act, e.v, $time);
            end
        end
    end

    task automatic expect_v(input string nm, input int unsigned kind,
                            input int unsigned idx, input logic [31:0] v);
        exp_t x;
        x.nm = nm; x.kind = kind; x.idx = idx; x.v = v;
        sbq.push_back(x);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_OUT; i++) m_out[i] = '0;
        for (int i = 0; i < N_IN; i++) begin m_d1[i] = '0; m_d2[i] = '0; end
        m_mask = '0; m_pend = '0; m_db = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] off;
        off = a - B_IN;
        if (off[1:0] == 2'b00 && off / 4 < N_IN) return 32'(m_d2[off / 4]);
        if (off == 4 * N_IN)       return 32'(m_db);
        if (off == 4 * (N_IN + 1)) return 32'(m_pend);
        off = a - B_OUT;
        if (off[1:0] == 2'b00 && off / 4 < N_OUT) return m_out[off / 4];
        if (off == 4 * N_OUT)       return 32'(m_mask);
        if (off == 4 * (N_OUT + 1)) return 32'(m_pend);
        return 32'h0;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        off = a - B_OUT;
        if (off[1:0] == 2'b00 && off / 4 < N_OUT) m_out[off / 4] = d;
        else if (off == 4 * N_OUT)                m_mask = d[N_BTN-1:0];
        else if (off == 4 * (N_OUT + 1))          m_pend = m_pend & ~d[N_BTN-1:0];
    endtask

    // Advance one clock; the synchronised inputs follow the pins two edges behind.
    task automatic tick();
        logic r;
        @(posedge clk);
        r = RST;
        #1;
        bus.iobus_wr = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (r) begin m_d1[i] = '0; m_d2[i] = '0; end
            else begin m_d2[i] = m_d1[i]; m_d1[i] = ext_in[i*IN_W +: IN_W]; end
        end
    endtask

    task automatic bus_cycle(input logic [31:0] a, input logic [31:0] d,
                             input logic w, input string nm);
        bus.iobus_addr = a;
        bus.iobus_out  = d;
        bus.iobus_wr   = w;
        expect_v(nm, K_RD, 0, model_read(a));
        if (w) model_write(a, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] v;
        int unsigned k;

        RST = 1'b1;
        ext_in = '0;
        btn_raw = '0;
        bus.iobus_addr = '0;
        bus.iobus_out = '0;
        bus.iobus_wr = 1'b0;
        model_reset();
        repeat (2) tick();
        bus.iobus_addr = MASK_A;
        expect_v("rst_out1", K_OUT, 1, 32'h0);
        expect_v("rst_intr", K_INTR, 0, 32'h0);
        expect_v("rst_mask_rd", K_RD, 0, 32'h0);
        tick();
        RST = 1'b0;
        tick();

        // Register write/read, ignored writes, unmapped read.
        bus_cycle(B_OUT + 32'd4, 32'hDEAD_BEEF, 1'b1, "wr_out1_old");
        tick();
        expect_v("out1_after_wr", K_OUT, 1, 32'hDEAD_BEEF);
        bus_cycle(B_OUT + 32'd4, 32'h0, 1'b0, "rd_out1");
        tick();
        bus_cycle(B_IN, 32'h1234_5678, 1'b1, "wr_in_region");
        tick();
        bus_cycle(B_IN, 32'h0, 1'b0, "rd_in0_after_wr");
        expect_v("out0_untouched", K_OUT, 0, 32'h0);
        expect_v("out1_untouched", K_OUT, 1, 32'hDEAD_BEEF);
        tick();
        bus_cycle(32'h1100_9000, 32'hFFFF_FFFF, 1'b1, "rd_unmapped");
        tick();
        expect_v("out1_after_unmapped_wr", K_OUT, 1, 32'hDEAD_BEEF);

        // Input port latency.
        ext_in[2*IN_W +: IN_W] = 16'hABCD;
        bus.iobus_addr = B_IN + 32'd8;
        expect_v("ext2_c0", K_RD, 0, 32'h0);
        tick();
        expect_v("ext2_c1", K_RD, 0, 32'h0);
        tick();
        expect_v("ext2_c2", K_RD, 0, 32'h0000_ABCD);
        tick();
        expect_v("ext2_c3", K_RD, 0, 32'h0000_ABCD);
        tick();

        // Bouncing button never settles.
        for (int j = 0; j < 30; j++) begin
            if (j % 3 == 0) btn_raw[0] = ~btn_raw[0];
            bus.iobus_addr = (j % 2 == 1) ? PEND_A : BTN_A;
            expect_v("bounce", K_RD, 0, 32'h0);
            tick();
        end
        btn_raw[0] = 1'b0;
        repeat (6) tick();
        bus_cycle(MASK_A, 32'h1, 1'b1, "wr_mask1");
        tick();

        // Clean press: db and pending after 2 sync edges plus DB stable edges.
        btn_raw[0] = 1'b1;
        for (int j = 0; j <= 12; j++) begin
            bus.iobus_addr = (j % 2 == 1) ? PEND_A : BTN_A;
            expect_v("press0", K_RD, 0, (j >= 2 + DB) ? 32'h1 : 32'h0);
            expect_v("press0_intr", K_INTR, 0, (j >= 3 + DB) ? 32'h1 : 32'h0);
            tick();
        end
        m_pend = 5'h01; m_db = 5'h01;

        // W1C clears pending; intr drops one cycle later.
        bus_cycle(CLR_A, 32'h1, 1'b1, "w1c_rd");
        expect_v("w1c_intr_c0", K_INTR, 0, 32'h1);
        tick();
        bus.iobus_addr = PEND_A;
        expect_v("w1c_pend_c1", K_RD, 0, 32'h0);
        expect_v("w1c_intr_c1", K_INTR, 0, 32'h1);
        tick();
        expect_v("w1c_intr_c2", K_INTR, 0, 32'h0);
        btn_raw[0] = 1'b0;
        repeat (12) tick();
        m_db = '0;

        // Rising edge on the same edge as a W1C of that bit: set wins.
        btn_raw[0] = 1'b1;
        repeat (1 + DB) tick();
        bus_cycle(CLR_A, 32'h1, 1'b1, "coinc_rd");
        tick();
        bus.iobus_addr = PEND_A;
        expect_v("coinc_pend_c0", K_RD, 0, 32'h1);
        tick();
        expect_v("coinc_pend_c1", K_RD, 0, 32'h1);
        expect_v("coinc_intr", K_INTR, 0, 32'h1);
        m_pend = 5'h01; m_db = 5'h01;
        bus_cycle(CLR_A, 32'h1, 1'b1, "coinc_clr_rd");
        tick();
        btn_raw[0] = 1'b0;
        bus_cycle(MASK_A, 32'h0, 1'b1, "wr_mask0");
        repeat (12) tick();
        m_db = '0;

        // Masked press, then unmask.
        btn_raw[2] = 1'b1;
        for (int j = 0; j <= 12; j++) begin
            bus.iobus_addr = PEND_A;
            expect_v("press2", K_RD, 0, (j >= 2 + DB) ? 32'h4 : 32'h0);
            expect_v("press2_intr", K_INTR, 0, 32'h0);
            tick();
        end
        m_pend = 5'h04; m_db = 5'h04;
        bus_cycle(MASK_A, 32'h4, 1'b1, "wr_mask4_rd");
        expect_v("unmask_intr_c0", K_INTR, 0, 32'h0);
        tick();
        bus_cycle(MASK_A, 32'h0, 1'b0, "rd_mask4");
        expect_v("unmask_intr_c1", K_INTR, 0, 32'h0);
        tick();
        expect_v("unmask_intr_c2", K_INTR, 0, 32'h1);
        v = 32'h8000_0000 | $urandom;
        bus_cycle(B_OUT + 32'd12, v, 1'b1, "wr_out3");
        tick();
        expect_v("pre_rst_out3", K_OUT, 3, v);
        expect_v("pre_rst_intr", K_INTR, 0, 32'h1);
        tick();

        // Asynchronous reset mid-run.
        RST = 1'b1;
        btn_raw = '0;
        model_reset();
        bus.iobus_addr = PEND_A;
        expect_v("arst_out3", K_OUT, 3, 32'h0);
        expect_v("arst_out1", K_OUT, 1, 32'h0);
        expect_v("arst_intr", K_INTR, 0, 32'h0);
        expect_v("arst_pend_rd", K_RD, 0, 32'h0);
        tick();
        RST = 1'b0;
        repeat (3) tick();

        // Randomized register traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, N_IN - 1);
                ext_in[k*IN_W +: IN_W] = IN_W'($urandom);
            end
            case ($urandom_range(0, 11))
                0, 1, 2, 3: a = B_OUT + 32'(4 * $urandom_range(0, N_OUT - 1));
                4:          a = MASK_A;
                5:          a = CLR_A;
                6, 7, 8, 9: a = B_IN + 32'(4 * $urandom_range(0, N_IN + 1));
                10:         a = ($urandom_range(0, 1) == 1) ? 32'h1100_9000 : B_OUT + 32'd24;
                default:    a = B_OUT + 32'(4 * $urandom_range(0, N_OUT + 1) + $urandom_range(1, 3));
            endcase
            d = $urandom;
            k = $urandom_range(0, N_OUT - 1);
            expect_v("rnd_out", K_OUT, k, m_out[k]);
            expect_v("rnd_intr", K_INTR, 0, 32'h0);
            bus_cycle(a, d, 1'($urandom_range(0, 1)), "rnd_rd");
            tick();
        end

        tick();
        tick();
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
